// File: rtl/encoder_bitscan_pkg.sv
// Shared types and helpers for the bit-scan encoder: FSM state, index width
// and the single-bit test that drives out_last.
package encoder_bitscan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int MAX_W = 256;

  function automatic int idx_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // Callers zero-extend their vector to MAX_W bits.
  function automatic logic popcount_is_one(input logic [MAX_W-1:0] vec);
    return (vec != '0) &&
           ((vec & (vec - {{(MAX_W-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/encoder_bitscan_if.sv
// Input/output valid-ready bundle for the bit-scan encoder.
// The encoder itself is the slave; the producer/consumer side is the master.
interface encoder_bitscan_if
  import encoder_bitscan_pkg::*;
#(
  parameter int W = 8
);
  localparam int IDX_W = idx_width(W);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_zero;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_zero
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_zero
  );
endinterface

// File: rtl/encoder_bitscan_prio_enc_lsb.sv
// Combinational priority encoder: index of the lowest set bit of vec.
// idx is 0 when vec is all zeros; any flags that case.
module encoder_bitscan_prio_enc_lsb
  import encoder_bitscan_pkg::*;
#(
  parameter  int W     = 8,
  localparam int IDX_W = idx_width(W)
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan downwards so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/encoder_bitscan.sv
// Sequential bit-scan encoder: accepts a W-bit vector and emits the index of
// every set bit, lowest first, one beat per output handshake.
module encoder_bitscan
  import encoder_bitscan_pkg::*;
#(
  parameter int W = 8
) (
  input logic               clk,
  input logic               rst,
  encoder_bitscan_if.slave  bus
);

  localparam int IDX_W = idx_width(W);

  state_t           state;
  logic [W-1:0]     res;
  logic [IDX_W-1:0] ld_idx;
  logic [IDX_W-1:0] rs_idx;
  logic             ld_any;
  logic             rs_any;
  logic             accept;
  logic             advance;
  logic             finish;

  encoder_bitscan_prio_enc_lsb #(.W(W)) u_enc_load (
    .vec (bus.in_vec),
    .idx (ld_idx),
    .any (ld_any)
  );

  encoder_bitscan_prio_enc_lsb #(.W(W)) u_enc_res (
    .vec (res),
    .idx (rs_idx),
    .any (rs_any)
  );

  // Ready on the final beat's handshake too, so vectors stream without a bubble.
  assign bus.in_ready = !rst &&
                        ((state == IDLE) ||
                         (bus.out_valid && bus.out_last && bus.out_ready));

  assign accept  = bus.in_valid && bus.in_ready;
  assign advance = bus.out_valid && bus.out_ready && !bus.out_last;
  assign finish  = bus.out_valid && bus.out_ready && bus.out_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      res           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
      bus.out_zero  <= 1'b0;
    end else if (accept) begin
      state         <= EMIT;
      res           <= bus.in_vec & (bus.in_vec - W'(1));
      bus.out_valid <= 1'b1;
      bus.out_idx   <= ld_idx;
      bus.out_last  <= !ld_any || popcount_is_one(MAX_W'(bus.in_vec));
      bus.out_zero  <= !ld_any;
    end else if (advance) begin
      // An empty residual here would be a broken invariant; end the vector.
      res           <= res & (res - W'(1));
      bus.out_idx   <= rs_idx;
      bus.out_last  <= !rs_any || popcount_is_one(MAX_W'(res));
      bus.out_zero  <= 1'b0;
    end else if (finish) begin
      state         <= IDLE;
      res           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
      bus.out_zero  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_encoder_bitscan.sv
// Self-checking bench for encoder_bitscan: directed scenarios followed by
// random vectors, all compared against a queue-based model of expected beats.
module tb_encoder_bitscan;

  localparam int W     = 8;
  localparam int IDX_W = $clog2(W);
  localparam int N_RAND = 10000;
  localparam int CYC_LIMIT = 90000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  encoder_bitscan_if #(.W(W)) bus ();

  encoder_bitscan #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int naccept = 0;

  // Expected beats still owed by the DUT, packed as {zero, last, idx}.
  logic [IDX_W+1:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // A vector's beats: every set bit in ascending order, or one zero beat.
  task automatic push_vector(input logic [W-1:0] vec);
    int n;
    n = 0;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        expq.push_back({1'b0, 1'b0, IDX_W'(i)});
        n++;
      end
    end
    if (n == 0) expq.push_back({1'b1, 1'b1, IDX_W'(0)});
    else expq[expq.size()-1][IDX_W] = 1'b1;
  endtask

  // One clock: drive, settle, compare against the model, advance the model.
  task automatic cycle(input logic v, input logic [W-1:0] vec, input logic rdy);
    logic exp_ready;
    bus.in_valid  = v;
    bus.in_vec    = vec;
    bus.out_ready = rdy;
    #1;
    exp_ready = (expq.size() == 0) || (expq.size() == 1 && rdy);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    chk("out_valid", 32'(bus.out_valid), 32'(expq.size() != 0));
    if (expq.size() != 0)
      chk("beat{zero,last,idx}", 32'({bus.out_zero, bus.out_last, bus.out_idx}), 32'(expq[0]));
    if (expq.size() != 0 && rdy) void'(expq.pop_front());
    if (v && exp_ready) begin
      push_vector(vec);
      naccept++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (expq.size() != 0 && budget < 200) begin
      cycle(1'b0, W'($urandom), 1'b1);
      budget++;
    end
    chk("drain_left", 32'(expq.size()), 32'd0);
    cycle(1'b0, '0, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_idx"},   32'(bus.out_idx),   32'd0);
    chk({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    chk({tag, "_out_zero"},  32'(bus.out_zero),  32'd0);
  endtask

  initial begin
    logic [W-1:0] rv;
    logic rvalid, rrdy;
    int mode;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_idle_outputs("rst");
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Two set bits: idx 2 then idx 5 (last), then ready again.
    cycle(1'b1, 8'b0010_0100, 1'b1);
    chk("two_bits_first_idx", 32'(bus.out_idx), 32'd2);
    chk("two_bits_first_last", 32'(bus.out_last), 32'd0);
    cycle(1'b0, 8'hAA, 1'b1);
    chk("two_bits_second_idx", 32'(bus.out_idx), 32'd5);
    chk("two_bits_second_last", 32'(bus.out_last), 32'd1);
    drain();

    // All-zero vector: one flagged beat, one cycle after accept.
    cycle(1'b1, 8'h00, 1'b1);
    chk("zero_vec_zero", 32'(bus.out_zero), 32'd1);
    drain();

    // All ones with out_ready toggling: each beat held during the stall.
    cycle(1'b1, 8'hFF, 1'b0);
    for (int k = 0; k < 16; k++) cycle(1'b1, W'($urandom), 1'(k % 2));
    drain();

    // Back-to-back single-bit vectors, no idle cycle in between.
    cycle(1'b1, 8'h80, 1'b1);
    chk("b2b_first_idx", 32'(bus.out_idx), 32'd7);
    cycle(1'b1, 8'h01, 1'b1);
    chk("b2b_second_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_second_idx", 32'(bus.out_idx), 32'd0);
    drain();

    // Reset right after the first beat of 8'h0F discards indices 1..3.
    cycle(1'b1, 8'h0F, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    check_idle_outputs("midrst");
    expq.delete();
    rst = 1'b0;
    cycle(1'b1, 8'h10, 1'b1);
    chk("after_rst_idx", 32'(bus.out_idx), 32'd4);
    drain();

    // Random vectors, including biased zero/full cases.
    naccept = 0;
    while (naccept < N_RAND && cyc < CYC_LIMIT) begin
      mode = $urandom_range(0, 9);
      if (mode == 0) rv = '0;
      else if (mode == 1) rv = '1;
      else rv = W'($urandom);
      rvalid = ($urandom_range(0, 7) != 0);
      rrdy   = ($urandom_range(0, 3) != 0);
      cycle(rvalid, rv, rrdy);
    end
    chk("rand_txn_count", 32'(naccept), 32'(N_RAND));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
